// File: rtl/fill_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fill_memory_pkg
//  Description : Shared definitions for the fill_memory storage block.
//                Holds the write-mode encodings used by producers and by
//                the storage block itself.
//  Revision    : 1.0 - initial release
// ============================================================================
package fill_memory_pkg;

    // Write-mode encodings presented on wr_mode_i
    localparam logic WR_ADDRESSED = 1'b0;   // write lands on wr_addr_i
    localparam logic WR_APPEND    = 1'b1;   // write lands on the append pointer

endpackage : fill_memory_pkg
`default_nettype wire

// File: rtl/fill_memory_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Plain one-write / one-read synchronous RAM. Read-first on a
//                same-address collision, registered read output that holds
//                while no read is requested. No reset on the array or the
//                read register so the structure maps onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       re_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]           rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and registered read port; the non-blocking read of mem_q
    // samples the old content, giving read-first behaviour on a collision.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_array
`default_nettype wire

// File: rtl/fill_memory.sv
`default_nettype none
// ============================================================================
//  Module      : fill_memory
//  Description : Parametrised storage block that widens narrow input words
//                (zero- or sign-extension) and tracks per-entry occupancy.
//                Supports addressed and append (auto-increment) writes, a
//                1-cycle registered read with a valid flag, an occupancy
//                count, a full flag, a dropped-append error pulse and a
//                synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module fill_memory
    import fill_memory_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 256,
    parameter int IN_WIDTH = 20,
    parameter int SIGN_EXT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       wr_en_i,
    input  logic                       wr_mode_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [IN_WIDTH-1:0]        wr_data_i,
    input  logic                       rd_en_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       wr_err_o
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             wr_err_q;
    logic             rd_valid_q;
    // Set when the last read targeted an empty entry (or after reset); the
    // RAM read register is then stale and the output is forced to zero.
    logic             rd_zero_q;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic             is_append;
    logic [AW-1:0]    wr_idx;
    logic             wr_accept;
    logic             wr_drop;
    logic             wr_new;
    logic             rd_hit;
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] mem_rdata;

    // Input widening: sign bit replicated or zero padding, nothing to do
    // when the input already matches the storage width.
    generate
        if (WIDTH == IN_WIDTH) begin : g_ext_none
            assign wr_word = wr_data_i;
        end else if (SIGN_EXT != 0) begin : g_ext_sign
            assign wr_word = {{(WIDTH-IN_WIDTH){wr_data_i[IN_WIDTH-1]}}, wr_data_i};
        end else begin : g_ext_zero
            assign wr_word = {{(WIDTH-IN_WIDTH){1'b0}}, wr_data_i};
        end
    endgenerate

    // Write decode and next-state for occupancy, pointer and count. Clear
    // overrides any write in the same cycle; an append while full is
    // dropped without touching state, while an addressed write may
    // overwrite regardless of fullness.
    always_comb begin
        is_append = (wr_mode_i == WR_APPEND);
        wr_idx    = is_append ? wr_ptr_q : wr_addr_i;
        wr_drop   = wr_en_i & ~clear_i & is_append & full_q;
        wr_accept = wr_en_i & ~clear_i & ~(is_append & full_q);
        wr_new    = wr_accept & ~valid_q[wr_idx];
        rd_hit    = rd_en_i & valid_q[rd_addr_i];

        valid_d   = valid_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;

        if (clear_i) begin
            valid_d  = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (wr_accept) begin
            valid_d[wr_idx] = 1'b1;
            if (is_append) begin
                // DEPTH is a power of two, so the natural AW-bit rollover
                // gives the DEPTH-1 -> 0 wrap.
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (wr_new) begin
                count_d = count_q + (AW+1)'(1);
            end
        end
    end

    // Control/status registers; full is derived from the next count so it
    // always agrees with count on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == FULL_COUNT);
            wr_err_q   <= wr_drop;
            rd_valid_q <= rd_hit;
            if (rd_en_i) begin
                rd_zero_q <= ~rd_hit;
            end
        end
    end

    // Storage; only occupied entries are read so the RAM register keeps
    // the last good word, and rd_zero_q masks it for empty-entry reads.
    mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (wr_accept),
        .waddr_i (wr_idx),
        .wdata_i (wr_word),
        .re_i    (rd_hit),
        .raddr_i (rd_addr_i),
        .rdata_o (mem_rdata)
    );

    assign rd_data_o  = rd_zero_q ? '0 : mem_rdata;
    assign rd_valid_o = rd_valid_q;
    assign count_o    = count_q;
    assign full_o     = full_q;
    assign wr_err_o   = wr_err_q;

endmodule : fill_memory
`default_nettype wire

// File: doc/fill_memory.md
# fill_memory

Parametrised single-clock storage block that accepts narrow input words, extends them to a wider storage width, and tracks per-entry occupancy. It generalises the plain addressed memory with an append (auto-increment) write mode, a registered read port with a valid flag, occupancy count, full flag, overflow error and synchronous clear. It sits between a data producer that emits narrow samples and a consumer that reads full-width words by address.

## Interface
- WIDTH, 32, stored and read word width
- DEPTH, 256, number of entries; power of two, ≥ 2
- IN_WIDTH, 20, input word width; must be ≤ WIDTH
- SIGN_EXT, 0, 1 = sign-extend input to WIDTH; 0 = zero-extend
- AW (local), $clog2(DEPTH), address width

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous clear of occupancy, pointer and count
- wr_en  in  1  write request
- wr_mode  in  1  0 = addressed write, 1 = append write
- wr_addr  in  AW  target entry for addressed write; ignored in append mode
- wr_data  in  IN_WIDTH  write data
- rd_en  in  1  read request
- rd_addr  in  AW  read entry
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  entry read was occupied
- count  out  AW+1  number of occupied entries, 0..DEPTH
- full  out  1  count == DEPTH
- wr_err  out  1  one-cycle pulse: append write dropped because full

## Operation
- Storage: DEPTH × WIDTH array, not reset. Occupancy: DEPTH-bit valid vector, reset/cleared to 0. Append pointer wr_ptr (AW bits).
- Extension: stored word = wr_data zero- or sign-extended (bit IN_WIDTH-1 replicated) per SIGN_EXT.
- Addressed write (wr_en, wr_mode=0): write entry wr_addr, set its valid bit; count +1 only if entry was previously invalid. Permitted when full (overwrite); never raises wr_err. wr_ptr unchanged.
- Append write (wr_en, wr_mode=1): if full, dropped, wr_err=1 for one cycle, no state change. Otherwise write entry wr_ptr, set valid, count +1 only if entry was invalid, wr_ptr ← wr_ptr+1 modulo DEPTH (wraps DEPTH-1 → 0).
- Read (rd_en): next cycle rd_data = stored word and rd_valid = 1 if entry occupied; else rd_data = 0, rd_valid = 0. rd_en=0: rd_data holds, rd_valid = 0.
- Read and write same entry, same cycle: read-first — returns previous content and previous valid bit.
- clear: valid vector, count, wr_ptr ← 0, full ← 0. Clear wins over a simultaneous write (write dropped, wr_err = 0). A read in the clear cycle returns pre-clear content.
- Reset mid-operation: all registered state returns to reset values immediately; array content undefined but unreachable (all entries invalid).

## Timing
- Reset values: rd_data 0, rd_valid 0, count 0, full 0, wr_err 0, wr_ptr 0, valid vector 0.
- Writes commit on the rising edge; count/full reflect the write from the following cycle.
- Read latency: 1 cycle, one read per cycle, fully pipelined.
- wr_err asserted the cycle after the dropped request, for exactly one cycle per dropped request.
- full and count are registered, glitch-free; full == (count == DEPTH) at all times.

## Structure
- Shared package fill_memory_pkg: wr_mode encodings WR_ADDRESSED = 1'b0, WR_APPEND = 1'b1.
- Sub-module mem_array: plain one-write/one-read synchronous RAM (WIDTH, DEPTH), read-first, no reset, inferable as block RAM. Occupancy, pointer, count, extension and error logic live in fill_memory.

## Test plan
- Reset then read address 5 -> rd_data 0, rd_valid 0, count 0, full 0.
- SIGN_EXT=1: append 20'h80001 then 20'h00002, read 0 and 1 -> 32'hFFF80001 then 32'h00000002, rd_valid 1; count 2. Same with SIGN_EXT=0 -> 32'h00080001.
- DEPTH=4: append 4 words -> full 1, count 4, wr_ptr wraps to 0; 5th append -> wr_err one-cycle pulse, entry 0 unchanged; addressed write to 2 while full -> accepted, no wr_err, count stays 4.
- Addressed write 0x123 to entry 7 twice -> count 1; append from empty with wr_ptr reaching 7 overwrites it, count unchanged for that write.
- Write 0xAAA and read entry 3 in same cycle after prior 0x555 -> rd_data 0x555; next read -> 0xAAA.
- clear asserted with append write in same cycle at count 3 -> count 0, full 0, wr_err 0, subsequent reads rd_valid 0; async rst asserted mid-burst -> all outputs 0 at once.
